// File: rtl/pll_video_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : pll_video_supervisor
// Brief   : Sequences a video PLL through power-up reset, lock acquisition,
//           lock-loss recovery and retry-limited fault latching (refclk domain).
// Revision: 1.0
// ============================================================================
module pll_video_supervisor #(
    parameter int POR_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       video_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int MAX_A = (POR_CYCLES > LOCK_STABLE_CYCLES) ? POR_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] C_POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       C_MAX_RETRIES  = 4'(MAX_RETRIES);

    localparam logic [2:0] S_POR       = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;
    logic [3:0]       w_retry_inc;
    logic             w_count_clr;
    logic             r_pll_rst;
    logic             r_video_rst;
    logic             r_ready;
    logic             r_fault;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_retry_inc = r_retry + 4'd1;
        w_count_clr = 1'b0;
        if (restart) begin
            // Restart also clears the counter when already in POR.
            w_state_nxt = S_POR;
            w_retry_nxt = 4'd0;
            w_count_clr = 1'b1;
        end else begin
            case (r_state)
                S_POR: begin
                    if (r_count == C_POR_LAST) w_state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (r_sync2) begin
                        w_state_nxt = S_STABLE;
                    end else if (r_count == C_TIMEOUT_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == C_MAX_RETRIES) ? S_FAULT : S_POR;
                    end
                end
                S_STABLE: begin
                    if (!r_sync2) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (r_count == C_STABLE_LAST) begin
                        w_state_nxt = S_RUN;
                        w_retry_nxt = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!r_sync2) w_state_nxt = S_POR;
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_POR;
                end
            endcase
        end

        // RUN and FAULT have no timed exit, so the counter rests at zero there.
        if (w_count_clr || (w_state_nxt != r_state) || (r_state == S_RUN) || (r_state == S_FAULT))
            w_count_nxt = '0;
        else
            w_count_nxt = r_count + C_CNT_ONE;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= S_POR;
            r_count     <= '0;
            r_retry     <= 4'd0;
            r_pll_rst   <= 1'b1;
            r_video_rst <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_sync1     <= pll_locked;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == S_POR) || (w_state_nxt == S_FAULT);
            r_video_rst <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign pll_rst     = r_pll_rst;
    assign video_rst   = r_video_rst;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_video_supervisor.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_video_supervisor
// Brief   : Scoreboard bench for pll_video_supervisor against a phase model.
// Revision: 1.0
// ============================================================================
module tb_pll_video_supervisor;

    localparam int P_POR     = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TIMEOUT = 32;
    localparam int P_RETRIES = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       video_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    pll_video_supervisor #(
        .POR_CYCLES         (P_POR),
        .LOCK_STABLE_CYCLES (P_STABLE),
        .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
        .MAX_RETRIES        (P_RETRIES)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .video_rst  (video_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #10 refclk = ~refclk;

    typedef enum {PH_POR, PH_WAIT, PH_STABLE, PH_RUN, PH_FAULT} phase_t;

    phase_t     m_phase;
    int         m_left;
    int         m_retries;
    logic       m_s1;
    logic       m_s2;
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [7:0] exp_now();
        logic [3:0] r;
        r = 4'(m_retries);
        return {(m_phase == PH_POR) || (m_phase == PH_FAULT), m_phase != PH_RUN,
                m_phase == PH_RUN, m_phase == PH_FAULT, r};
    endfunction

    task automatic model_reset();
        m_phase   = PH_POR;
        m_left    = P_POR;
        m_retries = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    // One refclk edge of the reference behaviour; lock seen two edges late.
    task automatic model_edge(input logic lk, input logic rs);
        logic ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rs) begin
            m_phase   = PH_POR;
            m_left    = P_POR;
            m_retries = 0;
        end else begin
            case (m_phase)
                PH_POR: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_WAIT; m_left = P_TIMEOUT; end
                end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STABLE;
                        m_left  = P_STABLE;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_retries++;
                            if (m_retries == P_RETRIES) m_phase = PH_FAULT;
                            else begin m_phase = PH_POR; m_left = P_POR; end
                        end
                    end
                end
                PH_STABLE: begin
                    if (!ls) begin
                        m_phase = PH_WAIT;
                        m_left  = P_TIMEOUT;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin m_phase = PH_RUN; m_retries = 0; end
                    end
                end
                PH_RUN: begin
                    if (!ls) begin m_phase = PH_POR; m_left = P_POR; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic lk, input logic rs);
        @(posedge refclk);
        #5;
        rst_n      = 1'b1;
        pll_locked = lk;
        restart    = rs;
        model_edge(lk, rs);
        exp_q.push_back(exp_now());
    endtask

    task automatic do_reset(input int hold);
        @(posedge refclk);
        #5;
        model_reset();
        exp_q.push_back(exp_now());
        rst_n = 1'b0;
        exp_q.push_back(exp_now());
        for (int i = 1; i < hold; i++) begin
            @(posedge refclk);
            #5;
            exp_q.push_back(exp_now());
        end
    endtask

    initial begin
        logic [7:0] act;
        logic [7:0] e;
        #1;
        forever begin
            @(posedge refclk or negedge rst_n);
            #2;
            act = {pll_rst, video_rst, ready, fault, retry_count};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL outputs t=%0t: no expectation queued, actual=%b", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e)
                begin
                    n_errors++;
                    $display("FAIL outputs t=%0t {pll_rst,video_rst,ready,fault,retry} actual=%b required=%b",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        int   len;
        logic lk;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        restart    = 1'b0;
        model_reset();
        exp_q.push_back(exp_now());

        // Clean power-up with lock already present
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        // No lock: two timeouts then fault, held
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);
        // Restart out of fault with lock present
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        // Single-cycle lock drop while running
        step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        // Lock drop part-way through the stability window
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        // Async reset mid-STABLE
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        do_reset(3);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        // Async reset mid-FAULT
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

        // Randomized lock segments, occasional restarts and resets
        for (int seg = 0; seg < 120; seg++) begin
            len = $urandom_range(1, 40);
            lk  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            for (int j = 0; j < len; j++) step(lk, $urandom_range(0, 63) == 0);
        end

        @(posedge refclk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: actual=%0d expectations left, required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
